// File: rtl/io_bus_bridge.sv
// IO bus bridge: round-robin arbitration of per-core IO requests onto a single
// memory-mapped bus, one transaction in flight, completions broadcast to all cores.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package io_bus_pkg;
  typedef logic [3:0] core_id_t;
  typedef logic [1:0] local_thread_idx_t;

  typedef struct packed {
    logic              is_store;
    logic [31:0]       address;
    logic [31:0]       value;
    local_thread_idx_t thread_idx;
  } ioreq_packet_t;

  typedef struct packed {
    core_id_t          core;
    local_thread_idx_t thread_idx;
    logic [31:0]       read_value;
  } iorsp_packet_t;
endpackage

module rr_arbiter #(
  parameter int NUM_REQUESTERS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQUESTERS-1:0] request,
  input  logic                      update_lru,
  output logic [NUM_REQUESTERS-1:0] grant_oh
);
  localparam int IDX_W = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1;

  // start_reg is the highest-priority index: one past the last winner.
  logic [IDX_W-1:0] start_reg;
  logic [IDX_W-1:0] grant_idx;
  logic             found;
  int               idx;

  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      idx = (int'(start_reg) + i) % NUM_REQUESTERS;
      if (!found && request[idx]) begin
        grant_oh[idx] = 1'b1;
        grant_idx     = IDX_W'(idx);
        found         = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      start_reg <= '0;
    end else if (update_lru && found) begin
      start_reg <= (grant_idx == IDX_W'(NUM_REQUESTERS - 1)) ? '0 : grant_idx + 1'b1;
    end
  end
endmodule

module io_bus_bridge
  import io_bus_pkg::*;
#(
  parameter int NUM_CORES      = `NUM_CORES,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_CORES-1:0] ior_request_valid,
  input  ioreq_packet_t        ior_request [NUM_CORES],
  output logic [NUM_CORES-1:0] ii_ready,
  output logic                 ii_response_valid,
  output iorsp_packet_t        ii_response,
  output logic                 io_write_en,
  output logic                 io_read_en,
  output logic [31:0]          io_address,
  output logic [31:0]          io_write_data,
  input  logic [31:0]          io_read_data,
  input  logic                 io_ack
);
  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t            state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  ioreq_packet_t     req_reg;
  logic [IDX_W-1:0]  core_reg;
  logic [NUM_CORES-1:0] grant_oh;
  logic [IDX_W-1:0]  grant_idx;
  logic              accept;

  rr_arbiter #(.NUM_REQUESTERS(NUM_CORES)) u_arb (
    .clk        (clk),
    .reset      (reset),
    .request    (ior_request_valid),
    .update_lru (accept),
    .grant_oh   (grant_oh)
  );

  always_comb begin
    grant_idx = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      if (grant_oh[i]) grant_idx = IDX_W'(i);
    end
  end

  assign ii_ready = (state_reg == IDLE && reset) ? grant_oh : '0;
  assign accept   = |(ii_ready & ior_request_valid);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      cnt_reg           <= '0;
      req_reg           <= '0;
      core_reg          <= '0;
      ii_response_valid <= 1'b0;
      ii_response       <= '0;
      io_write_en       <= 1'b0;
      io_read_en        <= 1'b0;
      io_address        <= '0;
      io_write_data     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            req_reg       <= ior_request[grant_idx];
            core_reg      <= grant_idx;
            io_write_en   <= ior_request[grant_idx].is_store;
            io_read_en    <= !ior_request[grant_idx].is_store;
            io_address    <= ior_request[grant_idx].address;
            io_write_data <= ior_request[grant_idx].value;
            cnt_reg       <= '0;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          io_write_en <= 1'b0;
          io_read_en  <= 1'b0;
          if (io_ack) begin
            ii_response_valid      <= 1'b1;
            ii_response.core       <= core_id_t'(core_reg);
            ii_response.thread_idx <= req_reg.thread_idx;
            ii_response.read_value <= req_reg.is_store ? 32'h0 : io_read_data;
            state_reg              <= RESPOND;
          end else begin
            cnt_reg   <= cnt_reg + 1'b1;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          // Ack is checked first so a late ack on the timeout cycle still returns real data.
          if (io_ack || cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            ii_response_valid      <= 1'b1;
            ii_response.core       <= core_id_t'(core_reg);
            ii_response.thread_idx <= req_reg.thread_idx;
            ii_response.read_value <= req_reg.is_store ? 32'h0 :
                                      (io_ack ? io_read_data : 32'hFFFF_FFFF);
            state_reg              <= RESPOND;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESPOND: begin
          ii_response_valid <= 1'b0;
          state_reg         <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_io_bus_bridge.sv
// Scoreboard bench for io_bus_bridge: directed requests push expected strobes and
// responses; a negedge monitor pops and compares whatever the bridge emits.
module tb_io_bus_bridge;
  import io_bus_pkg::*;

  localparam int NC = 4;
  localparam int TO = 16;

  typedef struct {
    logic        st;
    logic [31:0] a;
    logic [31:0] d;
  } strobe_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NC-1:0]        ior_request_valid;
  ioreq_packet_t        ior_request [NC];
  logic [NC-1:0]        ii_ready;
  logic                 ii_response_valid;
  iorsp_packet_t        ii_response;
  logic                 io_write_en, io_read_en;
  logic [31:0]          io_address, io_write_data, io_read_data;
  logic                 io_ack;

  io_bus_bridge #(.NUM_CORES(NC), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .ior_request_valid(ior_request_valid), .ior_request(ior_request),
    .ii_ready(ii_ready), .ii_response_valid(ii_response_valid), .ii_response(ii_response),
    .io_write_en(io_write_en), .io_read_en(io_read_en), .io_address(io_address),
    .io_write_data(io_write_data), .io_read_data(io_read_data), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  iorsp_packet_t exp_rsp[$];
  strobe_t       exp_strobe[$];
  int            grant_log[$];
  int            ack_delay = 0;
  logic [31:0]   ack_data = '0;
  int            strobe_cyc = 0, resp_cyc = 0, accept_cyc = 0, outstanding = 0;
  logic [NC-1:0] prev_ready = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  // Monitor: one-hot/one-cycle ready, single outstanding, strobe and response scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        if (ii_ready != '0) begin
          check("ready_onehot", 64'($countones(ii_ready)), 64'd1);
          check("ready_one_cycle", 64'(prev_ready != '0), 64'd0);
          if ((ii_ready & ior_request_valid) != '0) begin
            for (int i = 0; i < NC; i++) if (ii_ready[i]) grant_log.push_back(i);
            check("outstanding", 64'(outstanding), 64'd0);
            outstanding++;
            accept_cyc = cyc;
          end
        end
        prev_ready = ii_ready;
        if (io_read_en || io_write_en) begin
          strobe_cyc = cyc;
          check("strobe_exclusive", 64'(io_read_en && io_write_en), 64'd0);
          if (exp_strobe.size() == 0) unexpected("strobe");
          else begin
            strobe_t s;
            s = exp_strobe.pop_front();
            check("strobe_write_en", 64'(io_write_en), 64'(s.st));
            check("strobe_addr", 64'(io_address), 64'(s.a));
            if (s.st) check("strobe_wdata", 64'(io_write_data), 64'(s.d));
          end
        end
        if (ii_response_valid) begin
          resp_cyc = cyc;
          outstanding--;
          $display("rsp cycle=%0d core=%0d thread=%0d data=%08h", cyc,
                   ii_response.core, ii_response.thread_idx, ii_response.read_value);
          if (exp_rsp.size() == 0) unexpected("response");
          else begin
            iorsp_packet_t r;
            r = exp_rsp.pop_front();
            check("rsp_core", 64'(ii_response.core), 64'(r.core));
            check("rsp_thread", 64'(ii_response.thread_idx), 64'(r.thread_idx));
            check("rsp_data", 64'(ii_response.read_value), 64'(r.read_value));
          end
        end
      end
    end
  end

  // Device model: acks ack_delay cycles after the strobe (negative = never).
  initial begin
    io_ack = 1'b0;
    io_read_data = '0;
    forever begin
      @(negedge clk);
      if (reset && (io_read_en || io_write_en) && ack_delay >= 0) begin
        repeat (ack_delay) @(negedge clk);
        io_ack = 1'b1;
        io_read_data = ack_data;
        @(negedge clk);
        io_ack = 1'b0;
      end
    end
  end

  task automatic request(input int c, input logic st, input logic [31:0] a,
                         input logic [31:0] v, input logic [1:0] th);
    int n;
    ior_request[c] = '{is_store: st, address: a, value: v, thread_idx: th};
    ior_request_valid[c] = 1'b1;
    for (n = 0; n < 200; n++) begin
      @(negedge clk);
      if (ii_ready[c]) break;
    end
    if (!ii_ready[c]) unexpected("request_accept_timeout");
    @(posedge clk);
    #1;
    ior_request_valid[c] = 1'b0;
  endtask

  task automatic expect_txn(input logic st, input logic [31:0] a, input logic [31:0] d,
                            input int core, input logic [1:0] th, input logic [31:0] rv);
    exp_strobe.push_back('{st: st, a: a, d: d});
    exp_rsp.push_back('{core: core_id_t'(core), thread_idx: th, read_value: rv});
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_rsp.size() != 0 || exp_strobe.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (exp_rsp.size() != 0 || exp_strobe.size() != 0) begin
      unexpected("wait_done_timeout");
      exp_rsp.delete();
      exp_strobe.delete();
    end
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    ior_request_valid = '0;
    for (int i = 0; i < NC; i++) ior_request[i] = '0;
    #1;
    check("reset_ready", 64'(ii_ready), 64'd0);
    check("reset_rsp_valid", 64'(ii_response_valid), 64'd0);
    check("reset_strobes", 64'({io_read_en, io_write_en}), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Core 0 thread 2 load, ack three cycles after the strobe.
    ack_delay = 3; ack_data = 32'h1234;
    expect_txn(1'b0, 32'h100, 32'h0, 0, 2'd2, 32'h1234);
    request(0, 1'b0, 32'h100, 32'h0, 2'd2);
    wait_done();
    check("load_latency", 64'(resp_cyc - strobe_cyc), 64'd4);

    // Core 1 store, ack in ISSUE: response two cycles after accept.
    ack_delay = 0; ack_data = 32'h7777_7777;
    expect_txn(1'b1, 32'h200, 32'hDEADBEEF, 1, 2'd1, 32'h0);
    request(1, 1'b1, 32'h200, 32'hDEADBEEF, 2'd1);
    wait_done();
    check("store_latency", 64'(resp_cyc - accept_cyc), 64'd2);

    // Cores 0 and 1 requesting continuously: grants alternate.
    ack_delay = 0; ack_data = 32'h55AA_0001;
    grant_log.delete();
    expect_txn(1'b0, 32'h500, 32'h0, 0, 2'd0, 32'h55AA_0001);
    expect_txn(1'b0, 32'h600, 32'h0, 1, 2'd2, 32'h55AA_0001);
    expect_txn(1'b0, 32'h504, 32'h0, 0, 2'd1, 32'h55AA_0001);
    expect_txn(1'b0, 32'h604, 32'h0, 1, 2'd3, 32'h55AA_0001);
    fork
      begin
        request(0, 1'b0, 32'h500, 32'h0, 2'd0);
        request(0, 1'b0, 32'h504, 32'h0, 2'd1);
      end
      begin
        request(1, 1'b0, 32'h600, 32'h0, 2'd2);
        request(1, 1'b0, 32'h604, 32'h0, 2'd3);
      end
    join
    wait_done();
    check("rr_count", 64'(grant_log.size()), 64'd4);
    if (grant_log.size() == 4) begin
      check("rr_grant0", 64'(grant_log[0]), 64'd0);
      check("rr_grant1", 64'(grant_log[1]), 64'd1);
      check("rr_grant2", 64'(grant_log[2]), 64'd0);
      check("rr_grant3", 64'(grant_log[3]), 64'd1);
    end

    // Load never acked: forced error completion TO cycles after ISSUE.
    ack_delay = -1;
    expect_txn(1'b0, 32'h300, 32'h0, 3, 2'd1, 32'hFFFF_FFFF);
    request(3, 1'b0, 32'h300, 32'h0, 2'd1);
    wait_done();
    check("timeout_latency", 64'(resp_cyc - strobe_cyc), 64'(TO));

    // Next request after a timeout is accepted normally.
    ack_delay = 1; ack_data = 32'h1111_2222;
    expect_txn(1'b1, 32'h310, 32'hCAFEF00D, 2, 2'd0, 32'h0);
    request(2, 1'b1, 32'h310, 32'hCAFEF00D, 2'd0);
    wait_done();

    // Ack lands on the final WAIT cycle: real data wins over the timeout.
    ack_delay = TO - 1; ack_data = 32'hABCD_0123;
    expect_txn(1'b0, 32'h320, 32'h0, 1, 2'd3, 32'hABCD_0123);
    request(1, 1'b0, 32'h320, 32'h0, 2'd3);
    wait_done();
    check("ack_at_timeout_latency", 64'(resp_cyc - strobe_cyc), 64'(TO));

    // Reset during WAIT: transaction dropped, outputs cleared, pointer back to core 0.
    ack_delay = -1;
    exp_strobe.push_back('{st: 1'b0, a: 32'h400, d: 32'h0});
    request(0, 1'b0, 32'h400, 32'h0, 2'd1);
    repeat (3) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_strobes", 64'({io_read_en, io_write_en}), 64'd0);
    check("rst_address", 64'(io_address), 64'd0);
    check("rst_rsp", 64'({ii_response_valid, ii_response}), 64'd0);
    outstanding = 0;
    prev_ready = '0;
    @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (TO + 4) @(negedge clk);
    @(posedge clk);
    #1;
    ack_delay = 0; ack_data = 32'h0BAD_F00D;
    grant_log.delete();
    expect_txn(1'b0, 32'h700, 32'h0, 0, 2'd0, 32'h0BAD_F00D);
    expect_txn(1'b1, 32'h800, 32'h600D_0001, 1, 2'd2, 32'h0);
    fork
      request(0, 1'b0, 32'h700, 32'h0, 2'd0);
      request(1, 1'b1, 32'h800, 32'h600D_0001, 2'd2);
    join
    wait_done();
    check("post_reset_grants", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() == 2) check("post_reset_first", 64'(grant_log[0]), 64'd0);

    // Stray ack while idle: ignored.
    io_ack = 1'b1;
    io_read_data = 32'h9999_9999;
    @(posedge clk);
    #1;
    io_ack = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_ack_ready", 64'(ii_ready), 64'd0);
    check("idle_ack_strobes", 64'({io_read_en, io_write_en}), 64'd0);
    @(posedge clk);
    #1;
    ack_delay = 2; ack_data = 32'h0000_0042;
    expect_txn(1'b0, 32'h900, 32'h0, 2, 2'd3, 32'h0000_0042);
    request(2, 1'b0, 32'h900, 32'h0, 2'd3);
    wait_done();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
